// File: rtl/axi_stream_csum_sink.sv
// axi_stream_csum_sink
// Slave-side consumer of a beat stream. Accumulates a 16-bit ones'-complement
// Internet checksum over the kept bytes of each packet, folds it at end of
// packet and presents checksum, verify flag, error flag and byte count on a
// result handshake port.
//
// Handshakes: a beat transfers on a rising edge where tvalid and tready are
// both high; a result transfers on a rising edge where res_valid and
// res_ready are both high. A source holds its payload stable while valid is
// high and not yet accepted; tready and res_valid never depend
// combinationally on tvalid or res_ready.
module axi_stream_csum_sink #(
    parameter int DWIDTH = 76,
    parameter int UWIDTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tvalid,
    input  logic              tlast,
    input  logic [UWIDTH-1:0] tuser,
    input  logic [DWIDTH-1:0] tdata,
    output logic              tready,
    output logic              tuser_slv,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_csum,
    output logic              res_ok,
    output logic              res_err,
    output logic [15:0]       res_bytes
);

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_FOLD   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Per-packet accumulators
    logic [31:0] acc;
    logic        err;
    logic [15:0] bytes;

    // Registered result, loaded in FOLD and held through RESULT
    logic [15:0] csum_q;
    logic        ok_q;
    logic        err_q;
    logic [15:0] bytes_q;

    // Beat datapath
    logic [7:0]  keep;
    logic [63:0] masked;
    logic [3:0]  pop;
    logic [17:0] beat_sum;
    logic [32:0] acc_wide;
    logic [31:0] acc_next;
    logic [16:0] bytes_wide;
    logic [15:0] bytes_next;
    logic [16:0] s17;
    logic [15:0] fold_sum;
    logic        accept;

    // Bits above the keep mask carry nothing for this block.
    logic unused_tdata;
    assign unused_tdata = ^tdata[DWIDTH-1:72];

    assign accept = tvalid && (state == ST_ACC);

    // Mask dropped bytes, count kept ones, and form the end-around-carry sums.
    always_comb begin
        keep   = tdata[71:64];
        masked = '0;
        pop    = '0;
        for (int i = 0; i < 8; i++) begin
            masked[63-8*i -: 8] = tdata[63-8*i -: 8] & {8{keep[7-i]}};
            pop = pop + {3'b000, keep[7-i]};
        end
        beat_sum = {2'b00, masked[63:48]} + {2'b00, masked[47:32]}
                 + {2'b00, masked[31:16]} + {2'b00, masked[15:0]};
        // Adding the carry back cannot carry again: the low 32 bits are
        // smaller than beat_sum whenever the carry is set.
        acc_wide   = {1'b0, acc} + {15'b0, beat_sum};
        acc_next   = acc_wide[31:0] + {31'b0, acc_wide[32]};
        bytes_wide = {1'b0, bytes} + {13'b0, pop};
        bytes_next = bytes_wide[16] ? 16'hFFFF : bytes_wide[15:0];
        s17        = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
        fold_sum   = s17[15:0] + {15'b0, s17[16]};
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:    if (accept && tlast) state_next = ST_FOLD;
            ST_FOLD:   state_next = ST_RESULT;
            ST_RESULT: if (res_ready) state_next = ST_ACC;
            default:   state_next = ST_ACC;
        endcase
    end

    // State register, accumulators and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ACC;
            acc     <= '0;
            err     <= 1'b0;
            bytes   <= '0;
            csum_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            bytes_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc   <= acc_next;
                        err   <= err | tuser[0];
                        bytes <= bytes_next;
                    end
                end
                ST_FOLD: begin
                    csum_q  <= ~fold_sum;
                    ok_q    <= (fold_sum == 16'hFFFF);
                    err_q   <= err;
                    bytes_q <= bytes;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        acc   <= '0;
                        err   <= 1'b0;
                        bytes <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the registers; reset forces every output low in the
    // very cycle it is asserted.
    assign tready    = (state == ST_ACC) && !reset;
    assign res_valid = (state == ST_RESULT) && !reset;
    assign tuser_slv = (state == ST_RESULT) && ok_q && !reset;
    assign res_csum  = reset ? 16'h0000 : csum_q;
    assign res_ok    = ok_q && !reset;
    assign res_err   = err_q && !reset;
    assign res_bytes = reset ? 16'h0000 : bytes_q;

endmodule

// File: tb/tb_axi_stream_csum_sink.sv
// Testbench for axi_stream_csum_sink: directed checksum vectors plus random
// packets scored against a byte-level Internet checksum model.
module tb_axi_stream_csum_sink;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        tvalid;
    logic        tlast;
    logic [0:0]  tuser;
    logic [75:0] tdata;
    logic        tready;
    logic        tuser_slv;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_csum;
    logic        res_ok;
    logic        res_err;
    logic [15:0] res_bytes;

    always #5 clk = ~clk;

    axi_stream_csum_sink #(.DWIDTH(76), .UWIDTH(1)) dut (
        .clk(clk), .reset(reset), .tvalid(tvalid), .tlast(tlast),
        .tuser(tuser), .tdata(tdata), .tready(tready), .tuser_slv(tuser_slv),
        .res_valid(res_valid), .res_ready(res_ready), .res_csum(res_csum),
        .res_ok(res_ok), .res_err(res_err), .res_bytes(res_bytes)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    // expected result packed as {err, ok, bytes[15:0], csum[15:0]}
    logic [33:0] exp_q[$];

    // current packet under construction
    logic [63:0] pd[$];
    logic [7:0]  pk[$];
    logic        pu[$];

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: sum every kept byte pair as a big integer, then fold until
    // it fits in 16 bits.
    function automatic logic [33:0] model();
        longint unsigned s = 0;
        int cnt = 0;
        bit e = 0;
        logic [63:0] d;
        logic [7:0] k;
        logic [7:0] b;
        logic [15:0] sum16;
        logic [15:0] nbytes;
        for (int i = 0; i < pd.size(); i++) begin
            d = pd[i];
            k = pk[i];
            e = e | pu[i];
            for (int j = 0; j < 8; j++) begin
                b = k[7-j] ? d[63-8*j -: 8] : 8'h00;
                if (k[7-j]) cnt++;
                s += (j % 2 == 0) ? (longint'(b) << 8) : longint'(b);
            end
        end
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        sum16 = s[15:0];
        nbytes = (cnt > 65535) ? 16'hFFFF : cnt[15:0];
        return {e, (sum16 == 16'hFFFF), nbytes, ~sum16};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_pkt();
        pd.delete(); pk.delete(); pu.delete();
    endtask

    task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic u);
        pd.push_back(d); pk.push_back(k); pu.push_back(u);
    endtask

    task automatic random_pkt(input int nbeats, input int err_pct);
        int n;
        logic [7:0] k;
        clear_pkt();
        for (int i = 0; i < nbeats; i++) begin
            k = 8'hFF;
            if (i == nbeats - 1) begin
                n = $urandom_range(0, 8);
                k = 8'h00;
                for (int j = 0; j < n; j++) k[7-j] = 1'b1;
            end
            add_beat({$urandom, $urandom}, k, ($urandom_range(0, 99) < err_pct));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat's handshake.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
        int guard = 0;
        tvalid = 1'b1;
        tdata  = {4'($urandom), k, d};
        tuser  = u;
        tlast  = l;
        @(negedge clk);
        while (!tready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!tready) check("tready_timeout", {33'b0, tready}, 34'd1);
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic send_pkt(input int gap_max, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            drive_beat(pd[i], pk[i], pu[i], (i == pd.size() - 1));
            if (i != nbeats - 1) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Called right after the tlast handshake; checks latency, the result,
    // stability under backpressure and the accept timing.
    task automatic collect(input int hold, input bit junk);
        logic [33:0] e;
        e = exp_q.pop_front();
        @(negedge clk);
        check("fold_tready", {33'b0, tready}, 34'd0);
        check("fold_valid", {33'b0, res_valid}, 34'd0);
        @(negedge clk);
        check("res_valid", {33'b0, res_valid}, 34'd1);
        check("res_csum", {18'b0, res_csum}, {18'b0, e[15:0]});
        check("res_bytes", {18'b0, res_bytes}, {18'b0, e[31:16]});
        check("res_ok", {33'b0, res_ok}, {33'b0, e[32]});
        check("res_err", {33'b0, res_err}, {33'b0, e[33]});
        check("tuser_slv", {33'b0, tuser_slv}, {33'b0, e[32]});
        if (junk) begin
            tvalid = 1'b1;
            tlast  = 1'($urandom);
            tdata  = {12'($urandom), $urandom, $urandom};
        end
        repeat (hold) begin
            @(negedge clk);
            check("bp_tready", {33'b0, tready}, 34'd0);
            check("bp_valid", {33'b0, res_valid}, 34'd1);
            check("bp_stable", {res_err, res_ok, res_bytes, res_csum}, e);
            check("bp_slv", {33'b0, tuser_slv}, {33'b0, e[32]});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        @(negedge clk);
        check("acc_valid_drop", {33'b0, res_valid}, 34'd0);
        check("acc_tready", {33'b0, tready}, 34'd1);
        check("acc_slv_drop", {33'b0, tuser_slv}, 34'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {tready, res_valid, tuser_slv, res_ok, res_err, res_csum, res_bytes}, 37'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_valid", {33'b0, res_valid}, 34'd0);
            check("post_reset_tready", {33'b0, tready}, 34'd1);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        tdata = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_tready", {33'b0, tready}, 34'd1);
        check("idle_valid", {33'b0, res_valid}, 34'd0);
        @(posedge clk); #1;

        // single beat
        clear_pkt();
        add_beat(64'h4500_0073_0000_4000, 8'hFF, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 16'd8, 16'h7A8C});
        send_pkt(0, 1); collect(0, 0);

        // verifying packet
        clear_pkt();
        add_beat(64'h1234_EDCB_0000_0000, 8'hFF, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 16'd8, 16'h0000});
        send_pkt(0, 1); collect(2, 0);

        // carry wrap and odd tail
        clear_pkt();
        add_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        add_beat(64'h0100_0000_0000_0000, 8'h80, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 16'd9, 16'hFEFF});
        send_pkt(0, 2); collect(0, 0);

        // empty packet: a zero-keep last beat with junk payload
        clear_pkt();
        add_beat({$urandom, $urandom}, 8'h00, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 16'd0, 16'hFFFF});
        send_pkt(0, 1); collect(1, 0);

        // backpressure with the next packet already offered
        random_pkt(3, 0);
        exp_q.push_back(model());
        send_pkt(1, 3); collect(5, 1);
        random_pkt(2, 0);
        exp_q.push_back(model());
        send_pkt(0, 2); collect(0, 0);

        // error flag on the middle beat only, then a clean packet
        random_pkt(3, 0);
        pu[1] = 1'b1;
        exp_q.push_back(model());
        send_pkt(1, 3); collect(0, 0);
        random_pkt(3, 0);
        exp_q.push_back(model());
        send_pkt(1, 3); collect(0, 0);

        // reset after beat 2 of a 4-beat packet
        random_pkt(4, 20);
        send_pkt(0, 2);
        pulse_reset();
        random_pkt(4, 0);
        exp_q.push_back(model());
        send_pkt(1, 4); collect(1, 0);

        // reset while a result is pending
        random_pkt(2, 0);
        send_pkt(0, 2);
        @(negedge clk); @(negedge clk);
        check("pending_valid", {33'b0, res_valid}, 34'd1);
        @(posedge clk); #1;
        pulse_reset();

        // byte counter saturation over a long packet
        random_pkt(8200, 0);
        exp_q.push_back(model());
        send_pkt(0, 8200); collect(0, 0);

        // random packets
        for (int p = 0; p < 40; p++) begin
            random_pkt($urandom_range(1, 5), 15);
            exp_q.push_back(model());
            send_pkt(2, pd.size());
            collect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("exp_q_empty", 34'(exp_q.size()), 34'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_stream_csum_sink.md
# axi_stream_csum_sink

AXI-stream slave-side consumer for the L3/L4 checksum path: accepts packet beats on the slave end of an `axi_stream_if`-style stream and accumulates a 16-bit ones'-complement Internet checksum over the valid bytes. At end of packet it folds the sum and presents checksum, pass flag, error flag and byte count on a result handshake port. It also drives the `tuser_slv` back-channel to the master. It is the receiving end for any stream master in the checksum datapath.

## Interface
- `DWIDTH`, 76: beat width.
  - `tdata[63:0]` carries payload bytes 0..7; byte 0 is in `[63:56]` (network order).
  - `tdata[71:64]` is the keep mask; bit 71 ↔ byte 0.
  - `tdata[75:72]` is ignored.
- `UWIDTH`, 1: `tuser` width; bit 0 is the master error flag.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tvalid`  in  1  beat valid.
- `tlast`  in  1  last beat of packet.
- `tuser`  in  UWIDTH  per-beat user/error.
- `tdata`  in  DWIDTH  beat payload + keep.
- `tready`  out  1  beat accept.
- `tuser_slv`  out  1  back-channel; high while a passing result is presented.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accept.
- `res_csum`  out  16  ones'-complement of the folded sum.
- `res_ok`  out  1  folded sum == 16'hFFFF (checksum verifies).
- `res_err`  out  1  some beat of the packet had `tuser[0]`=1.
- `res_bytes`  out  16  count of kept bytes; saturates at 16'hFFFF.

## Operation
- **States.** ACC, FOLD, RESULT.
- **Reset.** While `reset`=1:
  - state is forced to ACC; `acc`, `err` and `bytes` are forced to 0;
  - all outputs are 0, including `tready`.
- **ACC.**
  - `tready`=1 except in the cycle `reset` is high.
  - Each handshake (`tvalid` & `tready`) performs:
    - masks bytes with keep = 0 to 8'h00;
    - forms four 16-bit words (bytes 0:1, 2:3, 4:5, 6:7) and an 18-bit `beat_sum`;
    - updates `acc` as 32-bit ones'-complement: `acc + beat_sum`, with carry-out of bit 31 added back into bit 0;
    - ORs `tuser[0]` into `err`;
    - adds popcount(keep) to `bytes`, saturating.
  - A handshake with `tlast`=1 goes to FOLD.
- **Keep rules.**
  - Keep must be 8'hFF on non-last beats.
  - On the last beat, keep must be contiguous from bit 71.
  - Violations are not flagged; masked bytes are simply zeroed and not counted.
- **FOLD** (1 cycle, `tready`=0):
  - `s17 = acc[31:16] + acc[15:0]`;
  - `sum = s17[15:0] + s17[16]` (16 bits, no further carry possible);
  - registers `res_csum = ~sum`, `res_ok = (sum==16'hFFFF)`, `res_err`, `res_bytes`;
  - goes to RESULT.
- **RESULT.**
  - `res_valid`=1; `tready`=0.
  - `tuser_slv = res_ok`.
  - All `res_*` outputs hold stable until `res_valid` & `res_ready`.
  - On that handshake: clears `acc`, `err`, `bytes`; drops `res_valid` and `tuser_slv`; goes to ACC.
- **Zero-keep last beat.** A `tlast` beat with keep = 0 still ends the packet. An empty packet yields `res_csum`=16'hFFFF, `res_ok`=0, `res_bytes`=0.
- **Reset mid-packet or mid-result.** The partial packet or pending result is discarded; no result is emitted.

## Timing
- Accept throughput: 1 beat/cycle within a packet.
- Latency: `tlast` handshake in cycle N → FOLD in N+1 → `res_valid`=1 in N+2.
- Result accept: `res_ready` sampled high in cycle M → `res_valid`=0 and `tready`=1 in M+1.
- Minimum inter-packet bubble: 2 cycles of `tready`=0 (FOLD plus one RESULT cycle).
- `tready` is a pure decode of the state register; there is no combinational path from `tvalid`/`res_ready` to `tready`.
- All `res_*` outputs and `tuser_slv` are registered.
- `tvalid` may drop mid-packet; `acc` holds.

## Test plan
- **Single beat.** `tdata[63:0]`=64'h4500_0073_0000_4000, keep 8'hFF, `tlast`=1 → 2 cycles later `res_valid`=1, `res_csum`=16'h7A8C, `res_ok`=0, `res_bytes`=8, `tuser_slv`=0.
- **Verifying packet.** One beat with words 16'h1234, 16'hEDCB, 0, 0, keep FF, `tlast` → `res_csum`=16'h0000, `res_ok`=1, `tuser_slv`=1 while `res_valid`.
- **Carry wrap / odd tail.**
  - Stimulus: beat 1 all bytes 8'hFF, keep FF; beat 2 byte0=8'h01, keep 8'h80, `tlast`.
  - Required: `res_csum`=16'hFEFF, `res_bytes`=9.
- **Backpressure.**
  - Stimulus: hold `res_ready`=0 for 5 cycles after `res_valid`, with `tvalid`=1 on the next packet.
  - Required: `tready`=0 throughout, `res_*` stable; `res_ready`=1 → `tready`=1 the next cycle, and the next packet's checksum is unaffected by the previous one.
- **Error flag.** 3-beat packet with `tuser`=1 on beat 2 only → `res_err`=1; the following clean packet → `res_err`=0.
- **Reset mid-packet.** Assert `reset` for 1 cycle after beat 2 of a 4-beat packet → no result emitted; all outputs are 0 during reset; the next full packet gives correct values.
